// File: rtl/instr_decode_stage_pkg.sv
// Shared RV32I decode constants: opcodes, instruction ids, immediate formats,
// occupancy states and the registered stage entry layout.
package instr_decode_stage_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [5:0] INSTR_INVALID = 6'd0;
    localparam logic [5:0] INSTR_LUI     = 6'd1;
    localparam logic [5:0] INSTR_AUIPC   = 6'd2;
    localparam logic [5:0] INSTR_JAL     = 6'd3;
    localparam logic [5:0] INSTR_JALR    = 6'd4;
    localparam logic [5:0] INSTR_BEQ     = 6'd5;
    localparam logic [5:0] INSTR_BNE     = 6'd6;
    localparam logic [5:0] INSTR_BLT     = 6'd7;
    localparam logic [5:0] INSTR_BGE     = 6'd8;
    localparam logic [5:0] INSTR_BLTU    = 6'd9;
    localparam logic [5:0] INSTR_BGEU    = 6'd10;
    localparam logic [5:0] INSTR_LB      = 6'd11;
    localparam logic [5:0] INSTR_LH      = 6'd12;
    localparam logic [5:0] INSTR_LW      = 6'd13;
    localparam logic [5:0] INSTR_LBU     = 6'd14;
    localparam logic [5:0] INSTR_LHU     = 6'd15;
    localparam logic [5:0] INSTR_SB      = 6'd16;
    localparam logic [5:0] INSTR_SH      = 6'd17;
    localparam logic [5:0] INSTR_SW      = 6'd18;
    localparam logic [5:0] INSTR_ADDI    = 6'd19;
    localparam logic [5:0] INSTR_SLTI    = 6'd20;
    localparam logic [5:0] INSTR_SLTIU   = 6'd21;
    localparam logic [5:0] INSTR_XORI    = 6'd22;
    localparam logic [5:0] INSTR_ORI     = 6'd23;
    localparam logic [5:0] INSTR_ANDI    = 6'd24;
    localparam logic [5:0] INSTR_SLLI    = 6'd25;
    localparam logic [5:0] INSTR_SRLI    = 6'd26;
    localparam logic [5:0] INSTR_SRAI    = 6'd27;
    localparam logic [5:0] INSTR_ADD     = 6'd28;
    localparam logic [5:0] INSTR_SUB     = 6'd29;
    localparam logic [5:0] INSTR_SLL     = 6'd30;
    localparam logic [5:0] INSTR_SLT     = 6'd31;
    localparam logic [5:0] INSTR_SLTU    = 6'd32;
    localparam logic [5:0] INSTR_XOR     = 6'd33;
    localparam logic [5:0] INSTR_SRL     = 6'd34;
    localparam logic [5:0] INSTR_SRA     = 6'd35;
    localparam logic [5:0] INSTR_OR      = 6'd36;
    localparam logic [5:0] INSTR_AND     = 6'd37;

    // FMT_SH is the shift-immediate form: only the shamt field is carried.
    typedef enum logic [2:0] {
        FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
    } imm_fmt_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic [5:0]  instr_id;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } entry_t;

    function automatic logic [31:0] imm_gen(input imm_fmt_e fmt, input logic [31:0] i);
        logic [31:0] r;
        case (fmt)
            FMT_I:   r = {{20{i[31]}}, i[31:20]};
            FMT_SH:  r = {27'b0, i[24:20]};
            FMT_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
            FMT_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            FMT_U:   r = {i[31:12], 12'b0};
            FMT_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: r = 32'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_decode_stage_rv32i_decoder.sv
// Purely combinational RV32I decoder: raw word to id, register fields,
// immediate and rd write-enable; unsupported words decode as INSTR_INVALID.
module rv32i_decoder
    import instr_decode_stage_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [5:0]  o_instr_id,
    output logic [4:0]  o_rs1_addr,
    output logic [4:0]  o_rs2_addr,
    output logic [4:0]  o_rd_addr,
    output logic        o_rd_we,
    output logic [31:0] o_imm,
    output logic        o_illegal
);

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [5:0] w_id;
    imm_fmt_e   w_fmt_raw;
    imm_fmt_e   w_fmt;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_use_rd;

    assign w_opc = i_instr[6:0];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];

    // Opcode compare covers instr[1:0] == 2'b11, so compressed words fall to default.
    always_comb begin
        w_id      = INSTR_INVALID;
        w_fmt_raw = FMT_NONE;
        case (w_opc)
            OPC_LUI:   begin w_id = INSTR_LUI;   w_fmt_raw = FMT_U; end
            OPC_AUIPC: begin w_id = INSTR_AUIPC; w_fmt_raw = FMT_U; end
            OPC_JAL:   begin w_id = INSTR_JAL;   w_fmt_raw = FMT_J; end
            OPC_JALR: begin
                w_fmt_raw = FMT_I;
                if (w_f3 == 3'b000) w_id = INSTR_JALR;
            end
            OPC_BRANCH: begin
                w_fmt_raw = FMT_B;
                case (w_f3)
                    3'b000:  w_id = INSTR_BEQ;
                    3'b001:  w_id = INSTR_BNE;
                    3'b100:  w_id = INSTR_BLT;
                    3'b101:  w_id = INSTR_BGE;
                    3'b110:  w_id = INSTR_BLTU;
                    3'b111:  w_id = INSTR_BGEU;
                    default: w_id = INSTR_INVALID;
                endcase
            end
            OPC_LOAD: begin
                w_fmt_raw = FMT_I;
                case (w_f3)
                    3'b000:  w_id = INSTR_LB;
                    3'b001:  w_id = INSTR_LH;
                    3'b010:  w_id = INSTR_LW;
                    3'b100:  w_id = INSTR_LBU;
                    3'b101:  w_id = INSTR_LHU;
                    default: w_id = INSTR_INVALID;
                endcase
            end
            OPC_STORE: begin
                w_fmt_raw = FMT_S;
                case (w_f3)
                    3'b000:  w_id = INSTR_SB;
                    3'b001:  w_id = INSTR_SH;
                    3'b010:  w_id = INSTR_SW;
                    default: w_id = INSTR_INVALID;
                endcase
            end
            OPC_OP_IMM: begin
                w_fmt_raw = FMT_I;
                case (w_f3)
                    3'b000: w_id = INSTR_ADDI;
                    3'b010: w_id = INSTR_SLTI;
                    3'b011: w_id = INSTR_SLTIU;
                    3'b100: w_id = INSTR_XORI;
                    3'b110: w_id = INSTR_ORI;
                    3'b111: w_id = INSTR_ANDI;
                    3'b001: begin
                        w_fmt_raw = FMT_SH;
                        if (w_f7 == 7'h00) w_id = INSTR_SLLI;
                    end
                    default: begin
                        w_fmt_raw = FMT_SH;
                        if (w_f7 == 7'h00)      w_id = INSTR_SRLI;
                        else if (w_f7 == 7'h20) w_id = INSTR_SRAI;
                    end
                endcase
            end
            OPC_OP: begin
                w_fmt_raw = FMT_R;
                case ({w_f7, w_f3})
                    {7'h00, 3'b000}: w_id = INSTR_ADD;
                    {7'h20, 3'b000}: w_id = INSTR_SUB;
                    {7'h00, 3'b001}: w_id = INSTR_SLL;
                    {7'h00, 3'b010}: w_id = INSTR_SLT;
                    {7'h00, 3'b011}: w_id = INSTR_SLTU;
                    {7'h00, 3'b100}: w_id = INSTR_XOR;
                    {7'h00, 3'b101}: w_id = INSTR_SRL;
                    {7'h20, 3'b101}: w_id = INSTR_SRA;
                    {7'h00, 3'b110}: w_id = INSTR_OR;
                    {7'h00, 3'b111}: w_id = INSTR_AND;
                    default:         w_id = INSTR_INVALID;
                endcase
            end
            default: w_id = INSTR_INVALID;
        endcase
    end

    assign w_fmt = (w_id == INSTR_INVALID) ? FMT_NONE : w_fmt_raw;

    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        case (w_fmt)
            FMT_R:         begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1; end
            FMT_I, FMT_SH: begin w_use_rs1 = 1'b1; w_use_rd  = 1'b1; end
            FMT_S, FMT_B:  begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            FMT_U, FMT_J:  w_use_rd = 1'b1;
            default:       w_use_rd = 1'b0;
        endcase
    end

    assign o_instr_id = w_id;
    assign o_rs1_addr = w_use_rs1 ? i_instr[19:15] : 5'd0;
    assign o_rs2_addr = w_use_rs2 ? i_instr[24:20] : 5'd0;
    assign o_rd_addr  = w_use_rd  ? i_instr[11:7]  : 5'd0;
    assign o_rd_we    = w_use_rd && (i_instr[11:7] != 5'd0);
    assign o_imm      = imm_gen(w_fmt, i_instr);
    assign o_illegal  = (w_id == INSTR_INVALID);

endmodule

// File: rtl/instr_decode_stage.sv
// RV32I decode stage: 1-cycle accept-to-output latency, strict FIFO order, flush drops everything.
// Backpressure through a 2-entry head/skid buffer (in_ready low only when full); DECODE_ILLEGAL_EN adds out_illegal.
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ID_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_instr_id,
    output logic [4:0]      out_rs1_addr,
    output logic [4:0]      out_rs2_addr,
    output logic [4:0]      out_rd_addr,
    output logic            out_rd_we,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic            out_illegal
`endif
);

    occ_e   r_state;
    occ_e   w_state_nxt;
    entry_t r_head;
    entry_t r_skid;
    entry_t w_dec_ent;

    logic [5:0]  w_dec_id;
    logic [4:0]  w_dec_rs1;
    logic [4:0]  w_dec_rs2;
    logic [4:0]  w_dec_rd;
    logic        w_dec_we;
    logic [31:0] w_dec_imm;
    logic        w_dec_illegal;

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_head_ld_dec;
    logic w_head_ld_skid;
    logic w_skid_ld;

    rv32i_decoder u_dec (
        .i_instr    (in_instr),
        .o_instr_id (w_dec_id),
        .o_rs1_addr (w_dec_rs1),
        .o_rs2_addr (w_dec_rs2),
        .o_rd_addr  (w_dec_rd),
        .o_rd_we    (w_dec_we),
        .o_imm      (w_dec_imm),
        .o_illegal  (w_dec_illegal)
    );

    always_comb begin
        w_dec_ent          = '0;
        w_dec_ent.instr_id = w_dec_id;
        w_dec_ent.rs1_addr = w_dec_rs1;
        w_dec_ent.rs2_addr = w_dec_rs2;
        w_dec_ent.rd_addr  = w_dec_rd;
        w_dec_ent.rd_we    = w_dec_we;
        w_dec_ent.imm      = w_dec_imm;
        w_dec_ent.pc       = in_pc;
        w_dec_ent.illegal  = w_dec_illegal;
    end

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= OCC_EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = OCC_EMPTY;
        end else begin
            case (r_state)
                OCC_EMPTY: if (w_in_xfer) w_state_nxt = OCC_ONE;
                OCC_ONE: begin
                    if (w_in_xfer && !w_out_xfer)      w_state_nxt = OCC_FULL;
                    else if (!w_in_xfer && w_out_xfer) w_state_nxt = OCC_EMPTY;
                end
                OCC_FULL:  if (w_out_xfer) w_state_nxt = OCC_ONE;
                default:   w_state_nxt = OCC_EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state != OCC_FULL);
        out_valid = (r_state != OCC_EMPTY);
    end

    // Head takes the new word only when it is (or is about to be) the oldest entry.
    assign w_head_ld_dec  = w_in_xfer && ((r_state == OCC_EMPTY) ||
                                          ((r_state == OCC_ONE) && w_out_xfer));
    assign w_head_ld_skid = w_out_xfer && (r_state == OCC_FULL);
    assign w_skid_ld      = w_in_xfer && !w_out_xfer && (r_state == OCC_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_skid <= '0;
        end else if (!flush) begin
            if (w_head_ld_dec)       r_head <= w_dec_ent;
            else if (w_head_ld_skid) r_head <= r_skid;
            if (w_skid_ld)           r_skid <= w_dec_ent;
        end
    end

    assign out_instr_id = r_head.instr_id;
    assign out_rs1_addr = r_head.rs1_addr;
    assign out_rs2_addr = r_head.rs2_addr;
    assign out_rd_addr  = r_head.rd_addr;
    assign out_rd_we    = r_head.rd_we;
    assign out_imm      = r_head.imm;
    assign out_pc       = r_head.pc;

`ifdef DECODE_ILLEGAL_EN
    assign out_illegal = r_head.illegal;
`else
    logic w_unused_illegal;
    assign w_unused_illegal = r_head.illegal;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed and randomised checks of instr_decode_stage against a mask/match RV32I
// reference and a queue model of the two-entry buffer.
module tb_instr_decode_stage;
    import instr_decode_stage_pkg::*;

    typedef struct packed {
        logic [5:0]  id;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] mask;
        logic [31:0] match;
        logic [5:0]  id;
        byte         fmt;
    } pat_t;

    localparam int NPAT = 37;
    pat_t pats [NPAT] = '{
        '{32'h0000007F, 32'h00000037, INSTR_LUI,   "U"},
        '{32'h0000007F, 32'h00000017, INSTR_AUIPC, "U"},
        '{32'h0000007F, 32'h0000006F, INSTR_JAL,   "J"},
        '{32'h0000707F, 32'h00000067, INSTR_JALR,  "I"},
        '{32'h0000707F, 32'h00000063, INSTR_BEQ,   "B"},
        '{32'h0000707F, 32'h00001063, INSTR_BNE,   "B"},
        '{32'h0000707F, 32'h00004063, INSTR_BLT,   "B"},
        '{32'h0000707F, 32'h00005063, INSTR_BGE,   "B"},
        '{32'h0000707F, 32'h00006063, INSTR_BLTU,  "B"},
        '{32'h0000707F, 32'h00007063, INSTR_BGEU,  "B"},
        '{32'h0000707F, 32'h00000003, INSTR_LB,    "I"},
        '{32'h0000707F, 32'h00001003, INSTR_LH,    "I"},
        '{32'h0000707F, 32'h00002003, INSTR_LW,    "I"},
        '{32'h0000707F, 32'h00004003, INSTR_LBU,   "I"},
        '{32'h0000707F, 32'h00005003, INSTR_LHU,   "I"},
        '{32'h0000707F, 32'h00000023, INSTR_SB,    "S"},
        '{32'h0000707F, 32'h00001023, INSTR_SH,    "S"},
        '{32'h0000707F, 32'h00002023, INSTR_SW,    "S"},
        '{32'h0000707F, 32'h00000013, INSTR_ADDI,  "I"},
        '{32'h0000707F, 32'h00002013, INSTR_SLTI,  "I"},
        '{32'h0000707F, 32'h00003013, INSTR_SLTIU, "I"},
        '{32'h0000707F, 32'h00004013, INSTR_XORI,  "I"},
        '{32'h0000707F, 32'h00006013, INSTR_ORI,   "I"},
        '{32'h0000707F, 32'h00007013, INSTR_ANDI,  "I"},
        '{32'hFE00707F, 32'h00001013, INSTR_SLLI,  "H"},
        '{32'hFE00707F, 32'h00005013, INSTR_SRLI,  "H"},
        '{32'hFE00707F, 32'h40005013, INSTR_SRAI,  "H"},
        '{32'hFE00707F, 32'h00000033, INSTR_ADD,   "R"},
        '{32'hFE00707F, 32'h40000033, INSTR_SUB,   "R"},
        '{32'hFE00707F, 32'h00001033, INSTR_SLL,   "R"},
        '{32'hFE00707F, 32'h00002033, INSTR_SLT,   "R"},
        '{32'hFE00707F, 32'h00003033, INSTR_SLTU,  "R"},
        '{32'hFE00707F, 32'h00004033, INSTR_XOR,   "R"},
        '{32'hFE00707F, 32'h00005033, INSTR_SRL,   "R"},
        '{32'hFE00707F, 32'h40005033, INSTR_SRA,   "R"},
        '{32'hFE00707F, 32'h00006033, INSTR_OR,    "R"},
        '{32'hFE00707F, 32'h00007033, INSTR_AND,   "R"}
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_instr_id;
    logic [4:0]  out_rs1_addr;
    logic [4:0]  out_rs2_addr;
    logic [4:0]  out_rd_addr;
    logic        out_rd_we;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
`ifdef DECODE_ILLEGAL_EN
    logic        out_illegal;
`endif

    instr_decode_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr_id (out_instr_id),
        .out_rs1_addr (out_rs1_addr),
        .out_rs2_addr (out_rs2_addr),
        .out_rd_addr  (out_rd_addr),
        .out_rd_we    (out_rd_we),
        .out_imm      (out_imm),
        .out_pc       (out_pc)
`ifdef DECODE_ILLEGAL_EN
        ,
        .out_illegal  (out_illegal)
`endif
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   n_acc = 0;
    int   n_out = 0;
    exp_t q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
        exp_t        e;
        byte         f;
        logic [31:0] sx;
        logic        u1, u2, ud;
        e     = '0;
        e.pc  = pc;
        e.ill = 1'b1;
        f     = "-";
        for (int k = 0; k < NPAT; k++) begin
            if ((w & pats[k].mask) == pats[k].match) begin
                e.id  = pats[k].id;
                e.ill = 1'b0;
                f     = pats[k].fmt;
            end
        end
        sx = w[31] ? 32'hFFFFFFFF : 32'h0;
        case (f)
            "I":     e.imm = (sx << 12) | (w >> 20);
            "H":     e.imm = (w >> 20) & 32'h1F;
            "S":     e.imm = (sx << 12) | ((w >> 20) & 32'hFE0) | ((w >> 7) & 32'h1F);
            "B":     e.imm = (sx << 12) | ((w << 4) & 32'h800) | ((w >> 20) & 32'h7E0) | ((w >> 7) & 32'h1E);
            "U":     e.imm = w & 32'hFFFFF000;
            "J":     e.imm = (sx << 20) | (w & 32'hFF000) | ((w >> 9) & 32'h800) | ((w >> 20) & 32'h7FE);
            default: e.imm = 32'h0;
        endcase
        u1 = (f == "R") || (f == "I") || (f == "H") || (f == "S") || (f == "B");
        u2 = (f == "R") || (f == "S") || (f == "B");
        ud = (f == "R") || (f == "I") || (f == "H") || (f == "U") || (f == "J");
        e.rs1 = u1 ? w[19:15] : 5'd0;
        e.rs2 = u2 ? w[24:20] : 5'd0;
        e.rd  = ud ? w[11:7]  : 5'd0;
        e.we  = ud && (w[11:7] != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        if ($urandom_range(0, 5) == 0) return r;
        k = $urandom_range(0, NPAT - 1);
        r = (r & ~pats[k].mask) | pats[k].match;
        if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
        if ($urandom_range(0, 9) == 0) r[29] = ~r[29];
        return r;
    endfunction

    task automatic check_state(input string ph);
        exp_t h;
        chk({ph, ":out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        chk({ph, ":in_ready"},  64'(in_ready),  64'(q.size() < 2));
        if (q.size() != 0) begin
            h = q[0];
            chk({ph, ":id"},  64'(out_instr_id), 64'(h.id));
            chk({ph, ":rs1"}, 64'(out_rs1_addr), 64'(h.rs1));
            chk({ph, ":rs2"}, 64'(out_rs2_addr), 64'(h.rs2));
            chk({ph, ":rd"},  64'(out_rd_addr),  64'(h.rd));
            chk({ph, ":we"},  64'(out_rd_we),    64'(h.we));
            chk({ph, ":imm"}, 64'(out_imm),      64'(h.imm));
            chk({ph, ":pc"},  64'(out_pc),       64'(h.pc));
`ifdef DECODE_ILLEGAL_EN
            chk({ph, ":ill"}, 64'(out_illegal),  64'(h.ill));
`endif
        end
    endtask

    task automatic reset_vals(input string ph);
        chk({ph, ":out_valid"}, 64'(out_valid),    64'(0));
        chk({ph, ":in_ready"},  64'(in_ready),     64'(1));
        chk({ph, ":id"},        64'(out_instr_id), 64'(0));
        chk({ph, ":rs1"},       64'(out_rs1_addr), 64'(0));
        chk({ph, ":rs2"},       64'(out_rs2_addr), 64'(0));
        chk({ph, ":rd"},        64'(out_rd_addr),  64'(0));
        chk({ph, ":we"},        64'(out_rd_we),    64'(0));
        chk({ph, ":imm"},       64'(out_imm),      64'(0));
        chk({ph, ":pc"},        64'(out_pc),       64'(0));
`ifdef DECODE_ILLEGAL_EN
        chk({ph, ":ill"},       64'(out_illegal),  64'(0));
`endif
    endtask

    // One clock: drive at the falling edge, check, then advance the model at the rising edge.
    task automatic cycle(input logic v, input logic [31:0] w, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        logic ix, ox;
        in_valid  = v;
        in_instr  = w;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_state("cyc");
        ix = v && (q.size() < 2);
        ox = ordy && (q.size() != 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (ox) begin q.delete(0); n_out++; end
            if (ix) begin q.push_back(model(w, pc)); n_acc++; end
        end
        @(negedge clk);
    endtask

    logic [31:0] wv [3];
    int          n0;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_instr = '0; in_pc = '0; out_ready = 1'b0;
        @(negedge clk);
        reset_vals("reset");
        rst_n = 1'b1;

        cycle(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
        chk("addi_valid", 64'(out_valid),    64'(1));
        chk("addi_id",    64'(out_instr_id), 64'(INSTR_ADDI));
        chk("addi_rd",    64'(out_rd_addr),  64'(1));
        chk("addi_rs1",   64'(out_rs1_addr), 64'(0));
        chk("addi_imm",   64'(out_imm),      64'(5));
        chk("addi_we",    64'(out_rd_we),    64'(1));

        cycle(1'b1, 32'h402081B3, 32'h104, 1'b1, 1'b0);
        chk("sub_id",  64'(out_instr_id), 64'(INSTR_SUB));
        chk("sub_rs1", 64'(out_rs1_addr), 64'(1));
        chk("sub_rs2", 64'(out_rs2_addr), 64'(2));
        chk("sub_rd",  64'(out_rd_addr),  64'(3));
        cycle(1'b1, 32'hFFF08093, 32'h108, 1'b1, 1'b0);
        chk("addim1_id",  64'(out_instr_id), 64'(INSTR_ADDI));
        chk("addim1_imm", 64'(out_imm),      64'(32'hFFFFFFFF));

        cycle(1'b1, 32'h40335293, 32'h10C, 1'b1, 1'b0);
        chk("srai_id",    64'(out_instr_id), 64'(INSTR_SRAI));
        chk("srai_shamt", 64'(out_imm[4:0]), 64'(3));
        cycle(1'b1, 32'h60335293, 32'h110, 1'b1, 1'b0);
        chk("badf7_id", 64'(out_instr_id), 64'(INSTR_INVALID));
        chk("badf7_we", 64'(out_rd_we),    64'(0));
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        for (int k = 0; k < 3; k++) wv[k] = gen_instr();
        n_acc = 0;
        for (int k = 0; k < 4; k++)
            cycle(1'b1, wv[n_acc < 3 ? n_acc : 2], 32'h200 + 32'(4 * n_acc), 1'b0, 1'b0);
        chk("stall_dut_in_ready", 64'(in_ready),  64'(0));
        chk("stall_dut_valid",    64'(out_valid), 64'(1));
        chk("stall_accepted",     64'(n_acc),     64'(2));
        n0 = n_out;
        for (int k = 0; k < 5; k++) begin
            if (n_acc < 3) cycle(1'b1, wv[n_acc], 32'h200 + 32'(4 * n_acc), 1'b1, 1'b0);
            else           cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        chk("release_emerged", 64'(n_out - n0), 64'(3));
        chk("release_idle",    64'(out_valid),  64'(0));

        cycle(1'b1, gen_instr(), 32'h300, 1'b0, 1'b0);
        cycle(1'b1, gen_instr(), 32'h304, 1'b0, 1'b0);
        chk("prefl_in_ready", 64'(in_ready), 64'(0));
        cycle(1'b1, gen_instr(), 32'h308, 1'b0, 1'b1);
        chk("flush_valid",    64'(out_valid), 64'(0));
        chk("flush_in_ready", 64'(in_ready),  64'(1));
        for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        cycle(1'b1, 32'hFFFFFFFF, 32'h400, 1'b1, 1'b0);
        chk("ones_id", 64'(out_instr_id), 64'(INSTR_INVALID));
        chk("ones_we", 64'(out_rd_we),    64'(0));
`ifdef DECODE_ILLEGAL_EN
        chk("ones_illegal", 64'(out_illegal), 64'(1));
`endif
        cycle(1'b1, 32'h00500093, 32'h404, 1'b0, 1'b0);
        cycle(1'b1, 32'h402081B3, 32'h408, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        reset_vals("async_reset");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 600; k++)
            cycle($urandom_range(0, 9) < 7, gen_instr(), $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("final_drained", 64'(out_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
